jtag_axil_fetch: RTL and testbench

AXI-lite master that drains captured JTAG scans out of the JTAG slave's register block. It programs the slave's interrupt-enable register, waits for the slave interrupt, and reads STATUS, IR, DATLEN and the scan-data RAM window over AXI-lite. Each scan is emitted as a header word followed by data words on a valid/ready stream. The block sits between the JTAG slave register block and the on-chip consumer (DMA/packetizer).

---
 rtl/jtag_axil_fetch.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_jtag_axil_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_axil_fetch.sv
// jtag_axil_fetch: AXI-lite master that keeps the JTAG slave's interrupt
// enable programmed, then on each interrupt reads STATUS, IR, DATLEN and the
// scan-data RAM window and emits the scan as a header word plus data words.
module jtag_axil_fetch #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        sclk,
    input  logic        reset_n,
    input  logic [1:0]  cfg_enable_i,
    input  logic        irq_i,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o,
    output logic [31:0] m_tdata_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    input  logic        m_tready_i,
    output logic        busy_o,
    output logic        err_o,
    output logic        trunc_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [3:0] {
        S_WR_EN, S_WR_B, S_IDLE, S_RD_STAT, S_RD_IR, S_RD_LEN, S_HDR, S_RD_DATA, S_DAT
    } state_t;

    // Sub-phase of a single AXI read: issue the address next cycle, wait arready, wait rvalid
    typedef enum logic [1:0] {RP_ISSUE, RP_ADDR, RP_DATA} rd_phase_t;

    localparam logic [16:0] MAX_WORDS_17 = 17'(MAX_WORDS);
    localparam logic [8:0]  MAX_WORDS_9  = 9'(MAX_WORDS);

    state_t      state_q, state_d;
    rd_phase_t   rd_phase_q, rd_phase_d;
    logic        wr_issued_q, wr_issued_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic        err_q, err_d, trunc_q, trunc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]  shadow_q, shadow_d, holdoff_q, holdoff_d;
    logic [7:0]  ir_q, ir_d;
    logic [8:0]  words_q, words_d, idx_q, idx_d;

    logic        is_read, rd_done;
    logic [31:0] rd_offset;
    logic [16:0] len_words;

    // Data words needed to hold DATLEN bits, rounded up to whole 32-bit words
    assign len_words = ({1'b0, m_axi_rdata_i[15:0]} + 17'd31) >> 5;

    // Register offset for whichever read the current state performs
    always_comb begin
        is_read   = 1'b1;
        rd_offset = 32'h0;
        case (state_q)
            S_RD_STAT: rd_offset = 32'h0000_0004;
            S_RD_IR:   rd_offset = 32'h0000_0008;
            S_RD_LEN:  rd_offset = 32'h0000_000C;
            S_RD_DATA: rd_offset = 32'h0000_0400 + {21'b0, idx_q, 2'b00};
            default:   is_read   = 1'b0;
        endcase
    end

    // Next-state and registered-output computation for the whole fetch sequence
    always_comb begin
        state_d     = state_q;
        rd_phase_d  = rd_phase_q;
        wr_issued_d = wr_issued_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        araddr_d    = araddr_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        err_d       = err_q;
        trunc_d     = trunc_q;
        frame_cnt_d = frame_cnt_q;
        shadow_d    = shadow_q;
        holdoff_d   = holdoff_q;
        ir_d        = ir_q;
        words_d     = words_q;
        idx_d       = idx_q;
        rd_done     = 1'b0;

        if (is_read) begin
            case (rd_phase_q)
                RP_ISSUE: begin
                    arvalid_d  = 1'b1;
                    araddr_d   = BASE_ADDR + rd_offset;
                    rd_phase_d = RP_ADDR;
                end
                RP_ADDR: begin
                    if (m_axi_arready_i) begin
                        arvalid_d  = 1'b0;
                        rready_d   = 1'b1;
                        rd_phase_d = RP_DATA;
                    end
                end
                default: begin
                    if (m_axi_rvalid_i) begin
                        rready_d   = 1'b0;
                        rd_phase_d = RP_ISSUE;
                        rd_done    = 1'b1;
                        if (m_axi_rresp_i != 2'b00) err_d = 1'b1;
                    end
                end
            endcase
        end

        case (state_q)
            S_WR_EN: begin
                if (!wr_issued_q) begin
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = BASE_ADDR;
                    wdata_d     = {30'b0, cfg_enable_i};
                    wr_issued_d = 1'b1;
                end else begin
                    if (awvalid_q && m_axi_awready_i) awvalid_d = 1'b0;
                    if (wvalid_q && m_axi_wready_i) wvalid_d = 1'b0;
                    if (!awvalid_d && !wvalid_d) begin
                        shadow_d    = wdata_q[1:0];
                        wr_issued_d = 1'b0;
                        bready_d    = 1'b1;
                        state_d     = S_WR_B;
                    end
                end
            end
            S_WR_B: begin
                if (bready_q && m_axi_bvalid_i) begin
                    bready_d  = 1'b0;
                    if (m_axi_bresp_i != 2'b00) err_d = 1'b1;
                    holdoff_d = 2'd3;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cfg_enable_i != shadow_q) begin
                    state_d = S_WR_EN;
                end else if (holdoff_q == 2'd0 && irq_i) begin
                    rd_phase_d = RP_ISSUE;
                    state_d    = S_RD_STAT;
                end else if (holdoff_q != 2'd0) begin
                    holdoff_d = holdoff_q - 2'd1;
                end
            end
            S_RD_STAT: begin
                if (rd_done) begin
                    if (m_axi_rdata_i[0]) begin
                        state_d = S_RD_IR;
                    end else begin
                        holdoff_d = 2'd3;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_RD_IR: begin
                if (rd_done) begin
                    ir_d    = m_axi_rdata_i[7:0];
                    state_d = S_RD_LEN;
                end
            end
            S_RD_LEN: begin
                if (rd_done) begin
                    if (len_words > MAX_WORDS_17) begin
                        words_d = MAX_WORDS_9;
                        trunc_d = 1'b1;
                    end else begin
                        words_d = len_words[8:0];
                    end
                    tdata_d  = {m_axi_rdata_i[23:16], ir_q, m_axi_rdata_i[15:0]};
                    tlast_d  = (len_words == 17'd0);
                    tvalid_d = 1'b1;
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                if (tvalid_q && m_tready_i) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        holdoff_d   = 2'd3;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = 9'd0;
                        state_d = S_RD_DATA;
                    end
                end
            end
            S_RD_DATA: begin
                if (rd_done) begin
                    tdata_d  = m_axi_rdata_i;
                    tlast_d  = (idx_q == words_q - 9'd1);
                    tvalid_d = 1'b1;
                    state_d  = S_DAT;
                end
            end
            S_DAT: begin
                if (tvalid_q && m_tready_i) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    idx_d    = idx_q + 9'd1;
                    if (tlast_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        holdoff_d   = 2'd3;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end
            end
            default: state_d = S_WR_EN;
        endcase
    end

    // State and output registers; reset restarts the sequence at the enable write
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WR_EN;
            rd_phase_q  <= RP_ISSUE;
            wr_issued_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= 32'h0;
            wdata_q     <= 32'h0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            araddr_q    <= 32'h0;
            tdata_q     <= 32'h0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            err_q       <= 1'b0;
            trunc_q     <= 1'b0;
            frame_cnt_q <= 16'h0;
            shadow_q    <= 2'b00;
            holdoff_q   <= 2'd0;
            ir_q        <= 8'h0;
            words_q     <= 9'd0;
            idx_q       <= 9'd0;
        end else begin
            state_q     <= state_d;
            rd_phase_q  <= rd_phase_d;
            wr_issued_q <= wr_issued_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            araddr_q    <= araddr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            err_q       <= err_d;
            trunc_q     <= trunc_d;
            frame_cnt_q <= frame_cnt_d;
            shadow_q    <= shadow_d;
            holdoff_q   <= holdoff_d;
            ir_q        <= ir_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
        end
    end

    assign m_axi_awaddr_o  = awaddr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = 4'hF;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_araddr_o  = araddr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;
    assign m_tdata_o       = tdata_q;
    assign m_tvalid_o      = tvalid_q;
    assign m_tlast_o       = tlast_q;
    assign busy_o          = (state_q != S_IDLE);
    assign err_o           = err_q;
    assign trunc_o         = trunc_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_jtag_axil_fetch.sv
// tb_jtag_axil_fetch: directed bench acting as the JTAG slave register block
// and the stream consumer, with hand-computed expected words and addresses.
module tb_jtag_axil_fetch;

    logic        sclk;
    logic        reset_n;
    logic [1:0]  cfg_enable_i;
    logic        irq_i;
    logic [31:0] m_axi_awaddr_o;
    logic        m_axi_awvalid_o;
    logic        m_axi_awready_i;
    logic [31:0] m_axi_wdata_o;
    logic [3:0]  m_axi_wstrb_o;
    logic        m_axi_wvalid_o;
    logic        m_axi_wready_i;
    logic [1:0]  m_axi_bresp_i;
    logic        m_axi_bvalid_i;
    logic        m_axi_bready_o;
    logic [31:0] m_axi_araddr_o;
    logic        m_axi_arvalid_o;
    logic        m_axi_arready_i;
    logic [31:0] m_axi_rdata_i;
    logic [1:0]  m_axi_rresp_i;
    logic        m_axi_rvalid_i;
    logic        m_axi_rready_o;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tlast_o;
    logic        m_tready_i;
    logic        busy_o;
    logic        err_o;
    logic        trunc_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int errors = 0;

    jtag_axil_fetch #(.MAX_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .sclk(sclk), .reset_n(reset_n), .cfg_enable_i(cfg_enable_i), .irq_i(irq_i),
        .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awvalid_o(m_axi_awvalid_o),
        .m_axi_awready_i(m_axi_awready_i), .m_axi_wdata_o(m_axi_wdata_o),
        .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wvalid_o(m_axi_wvalid_o),
        .m_axi_wready_i(m_axi_wready_i), .m_axi_bresp_i(m_axi_bresp_i),
        .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
        .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arvalid_o(m_axi_arvalid_o),
        .m_axi_arready_i(m_axi_arready_i), .m_axi_rdata_i(m_axi_rdata_i),
        .m_axi_rresp_i(m_axi_rresp_i), .m_axi_rvalid_i(m_axi_rvalid_i),
        .m_axi_rready_o(m_axi_rready_o), .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o),
        .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i), .busy_o(busy_o), .err_o(err_o),
        .trunc_o(trunc_o), .frame_cnt_o(frame_cnt_o)
    );

    // Free-running system clock, 10 time units per cycle
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Hard stop in case the sequence below ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Accept one enable-register write, optionally giving awready and wready in separate cycles
    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                                input bit split, input logic [1:0] bresp, input string tag);
        int n;
        n = 0;
        while (!(m_axi_awvalid_o === 1'b1 && m_axi_wvalid_o === 1'b1) && n < 100) begin
            @(negedge sclk); n++;
        end
        check_output({tag, " aw/w valid"}, {30'b0, m_axi_awvalid_o, m_axi_wvalid_o}, 32'h3);
        check_output({tag, " awaddr"}, m_axi_awaddr_o, addr);
        check_output({tag, " wdata"}, m_axi_wdata_o, data);
        check_output({tag, " wstrb"}, {28'b0, m_axi_wstrb_o}, 32'hF);
        if (split) begin
            m_axi_awready_i = 1'b1; @(negedge sclk); m_axi_awready_i = 1'b0;
            check_output({tag, " aw dropped w held"}, {30'b0, m_axi_awvalid_o, m_axi_wvalid_o}, 32'h1);
            m_axi_wready_i = 1'b1; @(negedge sclk); m_axi_wready_i = 1'b0;
        end else begin
            m_axi_awready_i = 1'b1; m_axi_wready_i = 1'b1;
            @(negedge sclk);
            m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0;
        end
        n = 0;
        while (m_axi_bready_o !== 1'b1 && n < 100) begin @(negedge sclk); n++; end
        check_output({tag, " bready"}, {31'b0, m_axi_bready_o}, 32'h1);
        m_axi_bvalid_i = 1'b1; m_axi_bresp_i = bresp;
        @(negedge sclk);
        m_axi_bvalid_i = 1'b0; m_axi_bresp_i = 2'b00;
    endtask

    // Serve one AXI read with the given address/response delays
    task automatic serve_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                              input int ar_dly, input int r_dly, input string tag);
        int n;
        n = 0;
        while (m_axi_arvalid_o !== 1'b1 && n < 200) begin @(negedge sclk); n++; end
        check_output({tag, " arvalid"}, {31'b0, m_axi_arvalid_o}, 32'h1);
        repeat (ar_dly) @(negedge sclk);
        check_output({tag, " araddr"}, m_axi_araddr_o, addr);
        check_output({tag, " ar phase"}, {30'b0, m_axi_arvalid_o, m_axi_rready_o}, 32'h2);
        m_axi_arready_i = 1'b1; @(negedge sclk); m_axi_arready_i = 1'b0;
        n = 0;
        while (m_axi_rready_o !== 1'b1 && n < 200) begin @(negedge sclk); n++; end
        check_output({tag, " r phase"}, {30'b0, m_axi_arvalid_o, m_axi_rready_o}, 32'h1);
        repeat (r_dly) @(negedge sclk);
        m_axi_rvalid_i = 1'b1; m_axi_rdata_i = data; m_axi_rresp_i = resp;
        @(negedge sclk);
        m_axi_rvalid_i = 1'b0; m_axi_rdata_i = 32'h0; m_axi_rresp_i = 2'b00;
    endtask

    // Consume one stream word after holding tready low for dly cycles
    task automatic take_word(input logic [31:0] data, input bit last, input int dly, input string tag);
        int n;
        n = 0;
        while (m_tvalid_o !== 1'b1 && n < 200) begin @(negedge sclk); n++; end
        check_output({tag, " tvalid, no read pending"}, {30'b0, m_tvalid_o, m_axi_arvalid_o}, 32'h2);
        repeat (dly) @(negedge sclk);
        check_output({tag, " tdata"}, m_tdata_o, data);
        check_output({tag, " tvalid/tlast"}, {30'b0, m_tvalid_o, m_tlast_o}, {30'b0, 1'b1, last});
        m_tready_i = 1'b1; @(negedge sclk); m_tready_i = 1'b0;
    endtask

    // Directed sequence: configure, normal scan, spurious irq, zero length, truncation, error, abort
    initial begin
        int n;
        logic [31:0] d;
        reset_n = 1'b0; cfg_enable_i = 2'b01; irq_i = 1'b0;
        m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0; m_axi_bresp_i = 2'b00; m_axi_bvalid_i = 1'b0;
        m_axi_arready_i = 1'b0; m_axi_rdata_i = 32'h0; m_axi_rresp_i = 2'b00; m_axi_rvalid_i = 1'b0;
        m_tready_i = 1'b0;
        repeat (3) @(negedge sclk);

        check_output("reset valids", {25'b0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                     m_axi_arvalid_o, m_axi_rready_o, m_tvalid_o, m_tlast_o}, 32'h0);
        check_output("reset wstrb", {28'b0, m_axi_wstrb_o}, 32'hF);
        check_output("reset flags", {16'b0, frame_cnt_o}, 32'h0);
        check_output("reset busy/err/trunc", {29'b0, busy_o, err_o, trunc_o}, 32'h4);

        $display("[TB] configure after reset");
        reset_n = 1'b1;
        expect_write(32'h0, 32'h1, 1'b0, 2'b00, "cfg");
        repeat (6) @(negedge sclk);
        check_output("cfg single write idle", {30'b0, busy_o, m_axi_awvalid_o}, 32'h0);

        $display("[TB] normal scan");
        irq_i = 1'b1;
        serve_read(32'h4, 32'h1, 2'b00, 0, 0, "n stat");
        irq_i = 1'b0;
        serve_read(32'h8, 32'h3C, 2'b00, 1, 0, "n ir");
        serve_read(32'hC, 32'h0005_0040, 2'b00, 0, 2, "n len");
        take_word(32'h053C_0040, 1'b0, 0, "n hdr");
        serve_read(32'h400, 32'hDEAD_BEEF, 2'b00, 0, 0, "n d0");
        take_word(32'hDEAD_BEEF, 1'b0, 1, "n d0");
        serve_read(32'h404, 32'h1234_5678, 2'b00, 2, 1, "n d1");
        take_word(32'h1234_5678, 1'b1, 0, "n d1");
        check_output("n frame/busy", {busy_o, 15'b0, frame_cnt_o}, 32'h0000_0001);

        $display("[TB] spurious interrupt");
        repeat (5) @(negedge sclk);
        irq_i = 1'b1;
        serve_read(32'h4, 32'h0, 2'b00, 0, 0, "sp stat");
        check_output("sp idle", {30'b0, busy_o, m_tvalid_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            check_output($sformatf("sp holdoff %0d", i), {31'b0, m_axi_arvalid_o}, 32'h0);
        end
        @(negedge sclk);
        check_output("sp irq re-taken", {31'b0, m_axi_arvalid_o}, 32'h1);
        irq_i = 1'b0;

        $display("[TB] zero length scan");
        serve_read(32'h4, 32'h1, 2'b00, 0, 0, "z stat");
        serve_read(32'h8, 32'hA5, 2'b00, 0, 0, "z ir");
        serve_read(32'hC, 32'h0007_0000, 2'b00, 0, 0, "z len");
        take_word(32'h07A5_0000, 1'b1, 2, "z hdr");
        check_output("z frame/busy/trunc", {busy_o, trunc_o, 14'b0, frame_cnt_o}, 32'h0000_0002);

        $display("[TB] truncated scan with backpressure");
        irq_i = 1'b1;
        serve_read(32'h4, 32'h1, 2'b00, 1, 2, "t stat");
        irq_i = 1'b0;
        serve_read(32'h8, 32'h12, 2'b00, 0, 0, "t ir");
        serve_read(32'hC, 32'h0003_FFFF, 2'b00, 0, 0, "t len");
        take_word(32'h0312_FFFF, 1'b0, 1, "t hdr");
        check_output("t trunc", {31'b0, trunc_o}, 32'h1);
        for (int i = 0; i < 256; i++) begin
            d = 32'hC0DE_0000 + 32'(i * 3);
            serve_read(32'h400 + 32'(i * 4), d, 2'b00, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)), $sformatf("t rd%0d", i));
            take_word(d, (i == 255), int'($urandom_range(0, 3)), $sformatf("t w%0d", i));
        end
        check_output("t frame/busy", {busy_o, 15'b0, frame_cnt_o}, 32'h0000_0003);

        $display("[TB] read error on IR");
        irq_i = 1'b1;
        serve_read(32'h4, 32'h1, 2'b00, 0, 0, "e stat");
        irq_i = 1'b0;
        check_output("e err before", {31'b0, err_o}, 32'h0);
        serve_read(32'h8, 32'h3C, 2'b10, 0, 0, "e ir");
        check_output("e err set", {31'b0, err_o}, 32'h1);
        serve_read(32'hC, 32'h0001_0020, 2'b00, 0, 0, "e len");
        take_word(32'h013C_0020, 1'b0, 0, "e hdr");
        serve_read(32'h400, 32'hCAFE_F00D, 2'b00, 0, 0, "e d0");
        take_word(32'hCAFE_F00D, 1'b1, 0, "e d0");
        check_output("e frame/err", {err_o, 15'b0, frame_cnt_o}, 32'h8000_0004);

        $display("[TB] reset abort during data read");
        irq_i = 1'b1;
        serve_read(32'h4, 32'h1, 2'b00, 0, 0, "a stat");
        irq_i = 1'b0;
        serve_read(32'h8, 32'h11, 2'b00, 0, 0, "a ir");
        serve_read(32'hC, 32'h0000_0040, 2'b00, 0, 0, "a len");
        take_word(32'h0011_0040, 1'b0, 0, "a hdr");
        n = 0;
        while (m_axi_arvalid_o !== 1'b1 && n < 100) begin @(negedge sclk); n++; end
        check_output("a data araddr", m_axi_araddr_o, 32'h400);
        reset_n = 1'b0;
        #1;
        check_output("a valids", {25'b0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                     m_axi_arvalid_o, m_axi_rready_o, m_tvalid_o, m_tlast_o}, 32'h0);
        check_output("a araddr", m_axi_araddr_o, 32'h0);
        check_output("a tdata", m_tdata_o, 32'h0);
        check_output("a flags", {busy_o, err_o, trunc_o, 13'b0, frame_cnt_o}, 32'h8000_0000);
        check_output("a wstrb", {28'b0, m_axi_wstrb_o}, 32'hF);
        @(negedge sclk);
        reset_n = 1'b1;
        expect_write(32'h0, 32'h1, 1'b0, 2'b00, "a restart");

        $display("[TB] enable change with split handshake and write error");
        repeat (2) @(negedge sclk);
        cfg_enable_i = 2'b10;
        expect_write(32'h0, 32'h2, 1'b1, 2'b10, "cfg2");
        check_output("cfg2 idle err", {30'b0, busy_o, err_o}, 32'h1);
        repeat (6) @(negedge sclk);
        check_output("cfg2 no rewrite", {30'b0, busy_o, m_axi_awvalid_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
